// File: rtl/sudoku_check_ctrl.sv
// sudoku_check_ctrl
//   Validates a 9x9 Sudoku board held in an external cell memory. It walks
//   27 constraint groups (rows 0-8, columns 9-17, 3x3 boxes 18-26). For each
//   group it reads the nine cells and checks that the values 1..9 each occur
//   exactly once.
//
//   Ports:
//     clock, reset_L        rising-edge clock, asynchronous active-low reset
//     start                 begin a scan; only sampled in IDLE
//     cell_rd, cell_addr    read strobe and cell index (9*row+col) to memory
//     cell_data             cell value, valid the cycle after cell_rd
//     busy                  high in FETCH/EVAL
//     done                  one-cycle pulse when the result is valid
//     board_valid           all groups passed (held)
//     fail_group            first failing group, 31 = none (held)
//     fail_count            number of failing groups (held)
//
//   Parameter EARLY_EXIT: 1 = stop at the first failing group,
//                         0 = scan every group and count the failures.
module sudoku_check_ctrl #(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic       clock,
  input  logic       reset_L,
  input  logic       start,
  output logic       cell_rd,
  output logic [6:0] cell_addr,
  input  logic [3:0] cell_data,
  output logic       busy,
  output logic       done,
  output logic       board_valid,
  output logic [4:0] fail_group,
  output logic [4:0] fail_count
);

  typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_e;

  localparam logic [4:0] NO_FAIL  = 5'd31;
  localparam logic [4:0] LAST_GRP = 5'd26;

  state_e     state_q, state_d;
  logic [4:0] grp_q, grp_d;
  logic [3:0] elem_q, elem_d;
  logic [8:0] mask_q, mask_d;
  logic       bad_q, bad_d;
  logic       rd_q;
  logic [4:0] fcnt_q, fcnt_d;
  logic [4:0] fgrp_q, fgrp_d;
  logic       bv_q, bv_d;

  // Address generation. The address is a pure function of (group, element).
  // Because group/element only change when a new read is issued, cell_addr
  // holds its last value whenever cell_rd is low.
  logic [3:0] row, col, bidx;

  always_comb begin
    row  = '0;
    col  = '0;
    bidx = '0;
    if (grp_q < 5'd9) begin
      row = grp_q[3:0];
      col = elem_q;
    end else if (grp_q < 5'd18) begin
      row = elem_q;
      col = 4'(grp_q - 5'd9);
    end else begin
      bidx = 4'(grp_q - 5'd18);
      row  = (bidx / 4'd3) * 4'd3 + elem_q / 4'd3;
      col  = (bidx % 4'd3) * 4'd3 + elem_q % 4'd3;
    end
  end

  assign cell_addr = {3'b000, row} * 7'd9 + {3'b000, col};

  // Data capture. rd_q marks the cycle in which cell_data is valid. Values
  // outside 1..9 set a sticky bad flag instead of a mask bit. A duplicate
  // leaves some value unseen, so a full mask is both necessary and sufficient.
  logic [8:0] oh;
  logic       dbad;
  logic [8:0] mask_nx;
  logic       bad_nx;
  logic       grp_fail;

  always_comb begin
    oh   = '0;
    dbad = (cell_data == 4'd0) || (cell_data > 4'd9);
    if (!dbad) oh = 9'd1 << (cell_data - 4'd1);
  end

  // In EVAL the ninth datum arrives in the same cycle, so the verdict uses
  // the combinational next mask rather than the register.
  assign mask_nx  = mask_q | (rd_q ? oh : 9'd0);
  assign bad_nx   = bad_q | (rd_q & dbad);
  assign grp_fail = (mask_nx != 9'h1FF) || bad_nx;

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    elem_d  = elem_q;
    mask_d  = mask_q;
    bad_d   = bad_q;
    fcnt_d  = fcnt_q;
    fgrp_d  = fgrp_q;
    bv_d    = bv_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          grp_d   = '0;
          elem_d  = '0;
          mask_d  = '0;
          bad_d   = 1'b0;
          fcnt_d  = '0;
          fgrp_d  = NO_FAIL;
          bv_d    = 1'b0;
        end
      end
      FETCH: begin
        mask_d = mask_nx;
        bad_d  = bad_nx;
        if (elem_q == 4'd8) state_d = EVAL;
        else                elem_d  = elem_q + 4'd1;
      end
      EVAL: begin
        mask_d = '0;
        bad_d  = 1'b0;
        if (grp_fail) begin
          fcnt_d = fcnt_q + 5'd1;
          if (fgrp_q == NO_FAIL) fgrp_d = grp_q;
        end
        if ((grp_fail && EARLY_EXIT) || grp_q == LAST_GRP) begin
          state_d = DONE;
          // Set here so the flag is already valid during the done pulse.
          bv_d    = (fcnt_d == 5'd0);
        end else begin
          state_d = FETCH;
          grp_d   = grp_q + 5'd1;
          elem_d  = '0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      grp_q   <= '0;
      elem_q  <= '0;
      mask_q  <= '0;
      bad_q   <= 1'b0;
      rd_q    <= 1'b0;
      fcnt_q  <= '0;
      fgrp_q  <= NO_FAIL;
      bv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      elem_q  <= elem_d;
      mask_q  <= mask_d;
      bad_q   <= bad_d;
      rd_q    <= cell_rd;
      fcnt_q  <= fcnt_d;
      fgrp_q  <= fgrp_d;
      bv_q    <= bv_d;
    end
  end

  assign cell_rd     = (state_q == FETCH);
  assign busy        = (state_q == FETCH) || (state_q == EVAL);
  assign done        = (state_q == DONE);
  assign board_valid = bv_q;
  assign fail_group  = fgrp_q;
  assign fail_count  = fcnt_q;

endmodule

// File: tb/tb_sudoku_check_ctrl.sv
// Directed bench for sudoku_check_ctrl. Two instances share clock and reset:
// dut0 stops at the first failing group, dut1 scans all groups. Cycle 0 is
// the cycle in which start is high; cycle n is n rising edges later.
module tb_sudoku_check_ctrl;

  logic       clock = 1'b0;
  logic       reset_L;
  logic       start0, start1;
  logic       rd0, rd1;
  logic [6:0] addr0, addr1;
  logic [3:0] data0 = '0, data1 = '0;
  logic       busy0, busy1, done0, done1, bv0, bv1;
  logic [4:0] fg0, fg1, fc0, fc1;

  logic [3:0] mem [0:127];
  int cyc, npass, nfail, ntot;
  int dc, nrd;
  int trace [0:8];
  bit sawdone;

  always #5 clock = ~clock;

  sudoku_check_ctrl #(.EARLY_EXIT(1'b1)) dut0 (
    .clock(clock), .reset_L(reset_L), .start(start0), .cell_rd(rd0),
    .cell_addr(addr0), .cell_data(data0), .busy(busy0), .done(done0),
    .board_valid(bv0), .fail_group(fg0), .fail_count(fc0));

  sudoku_check_ctrl #(.EARLY_EXIT(1'b0)) dut1 (
    .clock(clock), .reset_L(reset_L), .start(start1), .cell_rd(rd1),
    .cell_addr(addr1), .cell_data(data1), .busy(busy1), .done(done1),
    .board_valid(bv1), .fail_group(fg1), .fail_count(fc1));

  // Cell memory: data valid the cycle after the read strobe.
  always @(posedge clock) begin
    if (rd0) data0 <= mem[addr0];
    if (rd1) data1 <= mem[addr1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Classic shifted-pattern solution: every row, column and box is 1..9.
  task automatic load_solved();
    for (int i = 0; i < 128; i++) mem[i] = 4'd0;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        mem[9*r+c] = 4'(((r*3 + r/3 + c) % 9) + 1);
  endtask

  // Start a scan on dut d in the next (IDLE) cycle, optionally pulse start
  // again at cycle restart_at, and run until done or the cycle limit.
  task automatic run(input bit d, input int restart_at, input int limit,
                     output int dcyc, output int nreads);
    step();
    cyc = 0;
    if (d) start1 = 1'b1; else start0 = 1'b1;
    dcyc = -1;
    nreads = 0;
    while (cyc < limit && dcyc < 0) begin
      step();
      start0 = 1'b0;
      start1 = 1'b0;
      if (cyc == restart_at) begin
        if (d) start1 = 1'b1; else start0 = 1'b1;
      end
      if (d ? rd1 : rd0) nreads++;
      if (!d && cyc >= 221 && cyc <= 229) trace[cyc-221] = rd0 ? int'(addr0) : -1;
      if (d ? done1 : done0) dcyc = cyc;
    end
  endtask

  initial begin
    int exp_tr [0:8];
    exp_tr = '{30, 31, 32, 39, 40, 41, 48, 49, 50};
    npass = 0; nfail = 0; ntot = 0; cyc = 0;
    reset_L = 1'b0; start0 = 1'b0; start1 = 1'b0;
    load_solved();

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_cell_rd", rd0, 0);
    chk("rst_cell_addr", addr0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_board_valid", bv0, 0);
    chk("rst_fail_group", fg0, 31);
    chk("rst_fail_count", fc0, 0);
    #2 reset_L = 1'b1;
    step();

    // 1 + 4: solved board, full scan, box 4 address trace
    run(0, -1, 400, dc, nrd);
    chk("t1_done_cycle", dc, 271);
    chk("t1_reads", nrd, 243);
    chk("t1_board_valid", bv0, 1);
    chk("t1_fail_group", fg0, 31);
    chk("t1_fail_count", fc0, 0);
    for (int i = 0; i < 9; i++) chk($sformatf("t4_addr%0d", i), trace[i], exp_tr[i]);
    step();
    chk("t1_done_pulse", done0, 0);
    chk("t1_idle_busy", busy0, 0);
    chk("t1_bv_held", bv0, 1);

    // 2: swap (0,0)/(0,1) -> column 0 fails
    load_solved();
    mem[0] = 4'd2; mem[1] = 4'd1;
    run(0, -1, 400, dc, nrd);
    chk("t2_done_cycle", dc, 101);
    chk("t2_reads", nrd, 90);
    chk("t2_fail_group", fg0, 9);
    chk("t2_fail_count", fc0, 1);
    chk("t2_board_valid", bv0, 0);

    // 3: (8,8)=0, full scan on dut1 -> row 8, col 8, box 8
    load_solved();
    mem[80] = 4'd0;
    run(1, -1, 400, dc, nrd);
    chk("t3_done_cycle", dc, 271);
    chk("t3_reads", nrd, 243);
    chk("t3_fail_group", fg1, 8);
    chk("t3_fail_count", fc1, 3);
    chk("t3_board_valid", bv1, 0);

    // 5: duplicate 7 in row 4, then restart at cycle 60
    load_solved();
    mem[36] = 4'd7;
    run(0, -1, 400, dc, nrd);
    chk("t5_done_cycle", dc, 51);
    chk("t5_fail_group", fg0, 4);
    chk("t5_fail_count", fc0, 1);
    while (cyc < 59) step();
    chk("t5_fg_held", fg0, 4);
    chk("t5_fc_held", fc0, 1);
    load_solved();
    step();
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("t5_restart_cycle", cyc, 61);
    chk("t5_clr_fail_group", fg0, 31);
    chk("t5_clr_fail_count", fc0, 0);
    chk("t5_restart_busy", busy0, 1);
    while (cyc < 400 && !done0) step();
    chk("t5_redone_cycle", cyc, 331);
    chk("t5_redone_valid", bv0, 1);

    // 6a: reset mid-scan at cycle 120 (dut1 has already failed group 4)
    load_solved();
    mem[36] = 4'd7;
    step();
    cyc = 0;
    start1 = 1'b1;
    while (cyc < 120) begin
      step();
      start1 = 1'b0;
    end
    chk("t6_pre_fail_group", fg1, 4);
    chk("t6_pre_busy", busy1, 1);
    reset_L = 1'b0;
    #1;
    chk("t6_rst_cell_rd", rd1, 0);
    chk("t6_rst_busy", busy1, 0);
    chk("t6_rst_fail_group", fg1, 31);
    chk("t6_rst_fail_count", fc1, 0);
    chk("t6_rst_done", done1, 0);
    #2 reset_L = 1'b1;
    sawdone = 1'b0;
    repeat (300) begin
      step();
      if (done1) sawdone = 1'b1;
    end
    chk("t6_no_done", sawdone, 0);
    chk("t6_idle_busy", busy1, 0);

    // 6b: start during busy (cycle 30) is ignored
    load_solved();
    run(0, 30, 400, dc, nrd);
    chk("t6b_done_cycle", dc, 271);
    chk("t6b_reads", nrd, 243);
    chk("t6b_board_valid", bv0, 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
